// File: rtl/srl_tap_delay_pkg.sv
// Shared constants and helpers for the addressable SRL delay line.
// DSP datapath width and a constant-foldable clog2.
package srl_tap_delay_pkg;

    localparam int DSP_W     = 18;
    localparam int DSP_DEPTH = 128;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/srl_tap_delay_srl_store.sv
// Reset-free WIDTH x DEPTH shift array with a combinational tap mux.
// Kept free of reset so synthesis can map it onto SRL primitives.
module srl_store
    import srl_tap_delay_pkg::*;
#(
    parameter int WIDTH = DSP_W,
    parameter int DEPTH = DSP_DEPTH,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    a,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr_q [DEPTH];
    logic [WIDTH-1:0] sr_d [DEPTH];

    always_comb begin
        sr_d = sr_q;
        if (ce) begin
            sr_d[0] = d;
            for (int i = 1; i < DEPTH; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    // Addresses past the last stage select nothing and read as zero.
    always_comb begin
        q = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a == AW'(i)) begin
                q = sr_q[i];
            end
        end
    end

endmodule

// File: rtl/srl_tap_delay.sv
// Addressable shift-register delay line with registered tap output,
// fill tracking, per-tap valid flag and synchronous flush.
module srl_tap_delay
    import srl_tap_delay_pkg::*;
#(
    parameter int WIDTH = DSP_W,
    parameter int DEPTH = DSP_DEPTH,
    localparam int AW = clog2(DEPTH),
    localparam int FW = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             ce,
    input  logic             flush,
    input  logic [AW-1:0]    a,
    output logic [WIDTH-1:0] y,
    output logic             y_vld,
    output logic             full
);

    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    logic [WIDTH-1:0] tap;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_d;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;
    logic             y_vld_q;
    logic             y_vld_d;
    logic             in_range;
    logic             tap_written;

    srl_store #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_store (
        .clk(clk),
        .ce (ce),
        .d  (d),
        .a  (a),
        .q  (tap)
    );

    // A flush coinciding with a shift keeps only the incoming sample.
    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = ce ? FW'(1) : '0;
        end else if (ce && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + FW'(1);
        end
    end

    always_comb begin
        in_range    = FW'(a) < FILL_MAX;
        tap_written = FW'(a) < fill_q;
        y_d         = in_range ? tap : '0;
        y_vld_d     = in_range & tap_written & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q  <= '0;
            y_q     <= '0;
            y_vld_q <= 1'b0;
        end else begin
            fill_q  <= fill_d;
            y_q     <= y_d;
            y_vld_q <= y_vld_d;
        end
    end

    assign y     = y_q;
    assign y_vld = y_vld_q;
    assign full  = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_srl_tap_delay.sv
// Randomised bench for srl_tap_delay at DEPTH=128 and DEPTH=100,
// checked against a queue-based reference of the delay line.
module tb_srl_tap_delay;

    localparam int W  = 18;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  d = '0;
    logic [AW-1:0] a = '0;

    logic [W-1:0]  y0;
    logic [W-1:0]  y1;
    logic          v0;
    logic          v1;
    logic          f0;
    logic          f1;

    always #5 clk = ~clk;

    srl_tap_delay #(.WIDTH(W), .DEPTH(128)) dut_a (
        .clk(clk), .rst_n(rst_n), .d(d), .ce(ce), .flush(flush),
        .a(a), .y(y0), .y_vld(v0), .full(f0)
    );

    srl_tap_delay #(.WIDTH(W), .DEPTH(100)) dut_b (
        .clk(clk), .rst_n(rst_n), .d(d), .ce(ce), .flush(flush),
        .a(a), .y(y1), .y_vld(v1), .full(f1)
    );

    int           depth_m [2] = '{128, 100};
    logic [W-1:0] hist [2][$];
    int           fill_m [2] = '{0, 0};
    logic [W-1:0] exp_y [2];
    logic         exp_v [2];
    logic         exp_f [2];
    logic         exp_known [2];

    int tests_run = 0;
    int tests_failed = 0;

    // Reference: newest sample at queue front, fill counted per the rules.
    task automatic model_edge(input int k);
        int ai;
        ai = int'(a);
        if (!rst_n) begin
            exp_y[k] = '0;
            exp_v[k] = 1'b0;
            exp_known[k] = 1'b1;
            fill_m[k] = 0;
        end else begin
            if (ai >= depth_m[k]) begin
                exp_y[k] = '0;
                exp_v[k] = 1'b0;
                exp_known[k] = 1'b1;
            end else begin
                exp_v[k] = (ai < fill_m[k]) && !flush;
                exp_known[k] = ai < hist[k].size();
                exp_y[k] = exp_known[k] ? hist[k][ai] : '0;
            end
            if (flush) fill_m[k] = ce ? 1 : 0;
            else if (ce && fill_m[k] < depth_m[k]) fill_m[k]++;
        end
        if (ce) begin
            hist[k].push_front(d);
            if (hist[k].size() > depth_m[k]) void'(hist[k].pop_back());
        end
        exp_f[k] = (fill_m[k] == depth_m[k]);
    endtask

    task automatic tick(input int dv, input bit cev, input bit fv, input int av);
        d = W'(dv);
        ce = cev;
        flush = fv;
        a = AW'(av);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(0, 0, 0, 0);
        tests_run++;
        if (y0 !== '0 || v0 !== 1'b0 || f0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_a got y=%h v=%b f=%b want 0 0 0", y0, v0, f0);
        end
        tests_run++;
        if (y1 !== '0 || v1 !== 1'b0 || f1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_b got y=%h v=%b f=%b want 0 0 0", y1, v1, f1);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0);
            tests_run++;
            if (v0 !== 1'b0 || f0 !== 1'b0 || v1 !== 1'b0 || f1 !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_after_reset got v=%b%b f=%b%b want 00 00",
                         v0, v1, f0, f1);
            end
        end
    endtask

    task automatic test_basic();
        tick(1, 1, 0, 0);
        tick(2, 1, 0, 0);
        tick(3, 1, 0, 0);
        tick(0, 0, 0, 0);
        tests_run++;
        if (y0 !== W'(3) || v0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_a0 got y=%h v=%b want 3 1", y0, v0);
        end
        tick(0, 0, 0, 2);
        tests_run++;
        if (y0 !== W'(1) || v0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_a2 got y=%h v=%b want 1 1", y0, v0);
        end
        tick(0, 0, 0, 3);
        tests_run++;
        if (v0 !== 1'b0 || v1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_a3 got v=%b%b want 00", v0, v1);
        end
    endtask

    task automatic test_fill();
        rst_n = 1'b0;
        tick(0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 130; i++) begin
            tick(i, 1, 0, 0);
            tests_run++;
            if (f0 !== (i >= 127) || f0 !== exp_f[0] || f1 !== exp_f[1]) begin
                tests_failed++;
                $display("FAIL fill_full[%0d] got %b%b want %b%b",
                         i, f0, f1, exp_f[0], exp_f[1]);
            end
        end
        tick(0, 0, 0, 127);
        tests_run++;
        if (y0 !== W'(2) || v0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_a127 got y=%h v=%b want 2 1", y0, v0);
        end
        tests_run++;
        if (y1 !== '0 || v1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_oor_b got y=%h v=%b want 0 0", y1, v1);
        end
        tick(0, 0, 0, 0);
        tests_run++;
        if (y0 !== W'(129) || v0 !== 1'b1 || f0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_a0 got y=%h v=%b f=%b want 81 1 1", y0, v0, f0);
        end
    endtask

    task automatic test_flush();
        tick('h155, 1, 1, 5);
        tests_run++;
        if (v0 !== 1'b0 || v1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_cycle got v=%b%b want 00", v0, v1);
        end
        tick(0, 0, 0, 0);
        tests_run++;
        if (y0 !== W'('h155) || v0 !== 1'b1 || y1 !== W'('h155) || v1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_a0 got y=%h/%h v=%b%b want 155 11", y0, y1, v0, v1);
        end
        tick(0, 0, 0, 1);
        tests_run++;
        if (v0 !== 1'b0 || f0 !== 1'b0 || f1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_a1 got v=%b f=%b%b want 0 00", v0, f0, f1);
        end
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        tests_run++;
        if (v0 !== 1'b0 || v1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_no_ce got v=%b%b want 00", v0, v1);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) tick(int'($urandom), 1, 0, i);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (y0 !== '0 || v0 !== 1'b0 || f0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset got y=%h v=%b f=%b want 0 0 0", y0, v0, f0);
        end
        tick(0, 0, 0, 0);
        rst_n = 1'b1;
        tick('h2A, 1, 0, 0);
        tick(0, 0, 0, 0);
        tests_run++;
        if (y0 !== W'('h2A) || v0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_a0 got y=%h v=%b want 2a 1", y0, v0);
        end
        tick(0, 0, 0, 1);
        tests_run++;
        if (v0 !== 1'b0 || v1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_a1 got v=%b%b want 00", v0, v1);
        end
    endtask

    task automatic test_depth100();
        rst_n = 1'b0;
        tick(0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) tick(1000 + i, 1, 0, 0);
        tick(0, 0, 0, 99);
        tests_run++;
        if (y1 !== W'(1000) || v1 !== 1'b1 || f1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL d100_a99 got y=%h v=%b f=%b want 3e8 1 1", y1, v1, f1);
        end
        for (int t = 100; t < 128; t++) begin
            tick(0, 0, 0, t);
            tests_run++;
            if (y1 !== '0 || v1 !== 1'b0 || v0 !== exp_v[0]) begin
                tests_failed++;
                $display("FAIL d100_oor[%0d] got y=%h v=%b v0=%b want 0 0 %b",
                         t, y1, v1, v0, exp_v[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] yk;
        logic         vk;
        logic         fk;
        for (int n = 0; n < 1500; n++) begin
            tick(int'($urandom), $urandom_range(3) != 0, $urandom_range(15) == 0,
                 ($urandom_range(1) != 0) ? int'($urandom_range(7)) : int'($urandom_range(127)));
            for (int k = 0; k < 2; k++) begin
                yk = (k == 0) ? y0 : y1;
                vk = (k == 0) ? v0 : v1;
                fk = (k == 0) ? f0 : f1;
                tests_run++;
                if (vk !== exp_v[k] || fk !== exp_f[k] ||
                    (exp_known[k] && yk !== exp_y[k])) begin
                    tests_failed++;
                    $display("FAIL random[%0d] dut%0d a=%0d got y=%h v=%b f=%b want y=%h v=%b f=%b",
                             n, k, a, yk, vk, fk, exp_y[k], exp_v[k], exp_f[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_flush();
        test_reset_mid();
        test_depth100();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
